// File: rtl/hc_adder_tester.sv
// Stimulus/check stage for a 16-bit adder: drives directed then LFSR operands,
// waits SETTLE_CYCLES after each load, and tallies {cout,s} against a+b+cin.
module hc_adder_tester #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_vectors,
  output logic [15:0] dut_a,
  output logic [15:0] dut_b,
  output logic        dut_cin,
  input  logic [15:0] dut_s,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic        fail_seen,
  output logic [15:0] ff_a,
  output logic [15:0] ff_b,
  output logic        ff_cin,
  output logic [16:0] ff_got
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, DONE} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
  } vec_t;

  state_t      state;
  logic [15:0] nvec, idx, lfsr_a, lfsr_b;
  logic [7:0]  cnt;
  logic [16:0] exp_sum, got;
  logic [15:0] idx_nxt;
  vec_t        vec_nxt;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  // Three corner-case vectors first, then the paired LFSR stream.
  function automatic vec_t vec_at(input logic [15:0] i, input logic [15:0] la,
                                  input logic [15:0] lb);
    vec_t v;
    case (i)
      16'd0:   v = '{a: 16'h0000, b: 16'h0000, cin: 1'b0};
      16'd1:   v = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0};
      16'd2:   v = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1};
      default: v = '{a: la, b: lb, cin: la[15] ^ lb[15]};
    endcase
    return v;
  endfunction

  assign exp_sum = {1'b0, dut_a} + {1'b0, dut_b} + {16'd0, dut_cin};
  assign got     = {dut_cout, dut_s};
  assign idx_nxt = idx + 16'd1;
  assign vec_nxt = vec_at(idx_nxt, lfsr_a, lfsr_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_cin    <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      fail_seen  <= 1'b0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_cin     <= 1'b0;
      ff_got     <= '0;
      nvec       <= '0;
      idx        <= '0;
      cnt        <= '0;
      lfsr_a     <= SEED;
      lfsr_b     <= SEED ^ 16'hFFFF;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_count <= '0;
            fail_count <= '0;
            if (num_vectors != 16'd0) begin
              nvec      <= num_vectors;
              idx       <= '0;
              fail_seen <= 1'b0;
              ff_a      <= '0;
              ff_b      <= '0;
              ff_cin    <= 1'b0;
              ff_got    <= '0;
              {dut_a, dut_b, dut_cin} <= vec_at(16'd0, SEED, SEED ^ 16'hFFFF);
              lfsr_a    <= SEED;
              lfsr_b    <= SEED ^ 16'hFFFF;
              state     <= LOAD;
              busy      <= 1'b1;
              done      <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          cnt   <= 8'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == 8'd0) state <= CHECK;
          else             cnt   <= cnt - 8'd1;
        end
        CHECK: begin
          if (got == exp_sum) begin
            if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
          end else begin
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              ff_a      <= dut_a;
              ff_b      <= dut_b;
              ff_cin    <= dut_cin;
              ff_got    <= got;
            end
          end
          if (idx == nvec - 16'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx_nxt;
            {dut_a, dut_b, dut_cin} <= vec_nxt;
            // LFSR values are consumed only from vector 3 onward.
            if (idx_nxt >= 16'd3) begin
              lfsr_a <= lfsr_step(lfsr_a);
              lfsr_b <= lfsr_step(lfsr_b);
            end
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_adder_tester.sv
// Bench for hc_adder_tester: behavioural adder (optionally with s[0] stuck low),
// run-level expectations queued at start and checked when done rises.
module tb_hc_adder_tester;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, fault = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [15:0] dut_a, dut_b, dut_s, pass_count, fail_count, ff_a, ff_b;
  logic        dut_cin, dut_cout, busy, done, fail_seen, ff_cin;
  logic [16:0] ff_got, model_sum;

  hc_adder_tester #(.SETTLE_CYCLES(2), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin), .dut_s(dut_s),
    .dut_cout(dut_cout), .busy(busy), .done(done), .pass_count(pass_count),
    .fail_count(fail_count), .fail_seen(fail_seen), .ff_a(ff_a), .ff_b(ff_b),
    .ff_cin(ff_cin), .ff_got(ff_got)
  );

  assign model_sum = {1'b0, dut_a} + {1'b0, dut_b} + {16'd0, dut_cin};
  assign dut_s     = fault ? {model_sum[15:1], 1'b0} : model_sum[15:0];
  assign dut_cout  = model_sum[16];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          pc, fc;
    logic        fs;
    logic [15:0] fa, fb;
    logic        fcin;
    logic [16:0] fgot;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, fails = 0;
  logic done_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: one queued expectation per rising edge of done.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_latency", cyc,        mon_e.done_cyc);
        chk("pass_count",   pass_count, mon_e.pc);
        chk("fail_count",   fail_count, mon_e.fc);
        chk("fail_seen",    fail_seen,  mon_e.fs);
        chk("ff_a",         ff_a,       mon_e.fa);
        chk("ff_b",         ff_b,       mon_e.fb);
        chk("ff_cin",       ff_cin,     mon_e.fcin);
        chk("ff_got",       ff_got,     mon_e.fgot);
        chk("busy_at_done", busy,       0);
      end
    end
    done_q = done;
  end

  task automatic start_run(input logic [15:0] n, input int lat, input int pc, input int fc,
                           input logic fs, input logic [15:0] fa, input logic [15:0] fb,
                           input logic fcin, input logic [16:0] fgot);
    exp_t e;
    @(negedge clk); start = 1'b1; num_vectors = n;
    @(posedge clk); #1; start = 1'b0;
    e.pc = pc; e.fc = fc; e.fs = fs; e.fa = fa; e.fb = fb; e.fcin = fcin; e.fgot = fgot;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) return;
    end
    tests++; fails++;
    $display("FAIL wait_done: got no done within %0d cycles expected done=1", budget);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);       chk({tag, "_done"}, done, 0);
    chk({tag, "_a"}, dut_a, 0);         chk({tag, "_b"}, dut_b, 0);
    chk({tag, "_cin"}, dut_cin, 0);     chk({tag, "_pass"}, pass_count, 0);
    chk({tag, "_fail"}, fail_count, 0); chk({tag, "_fseen"}, fail_seen, 0);
    chk({tag, "_ffa"}, ff_a, 0);        chk({tag, "_ffb"}, ff_b, 0);
    chk({tag, "_ffcin"}, ff_cin, 0);    chk({tag, "_ffgot"}, ff_got, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted
    rst = 1'b1; start = 1'b1; num_vectors = 16'd4;
    repeat (3) @(posedge clk);
    #1 chk_zero("rst");
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    // Zero-vector run: done immediately, busy never
    start_run(16'd0, 0, 0, 0, 1'b0, 16'h0, 16'h0, 1'b0, 17'h0);
    chk("zero_busy", busy, 0);
    wait_done(5);
    @(negedge clk);
    chk("zero_busy_after", busy, 0);

    // Clean run, 4 vectors; vector 3 is the first LFSR vector
    start_run(16'd4, 16, 4, 0, 1'b0, 16'h0, 16'h0, 1'b0, 17'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("v3_a", dut_a, 32'hACE1);
    chk("v3_b", dut_b, 32'h531E);
    chk("v3_cin", dut_cin, 1);
    chk("v3_s", dut_s, 0);
    chk("v3_cout", dut_cout, 1);
    wait_done(40);

    // s[0] stuck low: only vector 2 fails
    fault = 1'b1;
    start_run(16'd3, 12, 2, 1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE);
    wait_done(40);

    // Vector 4 (59C3+A63D+1) also fails; first-fail capture must keep vector 2
    start_run(16'd5, 20, 3, 2, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("v4_a", dut_a, 32'h59C3);
    chk("v4_b", dut_b, 32'hA63D);
    chk("v4_cin", dut_cin, 1);
    wait_done(40);
    fault = 1'b0;

    // Reset during SETTLE of vector 1, then a fresh clean run
    start_run(16'd4, 16, 4, 0, 1'b0, 16'h0, 16'h0, 1'b0, 17'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_v1_a", dut_a, 32'hFFFF);
    chk("mid_busy", busy, 1);
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1 chk_zero("midrst");
    @(negedge clk); rst = 1'b0;
    start_run(16'd4, 16, 4, 0, 1'b0, 16'h0, 16'h0, 1'b0, 17'h0);
    wait_done(40);

    // start while busy is ignored
    start_run(16'd3, 12, 3, 0, 1'b0, 16'h0, 16'h0, 1'b0, 17'h0);
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; num_vectors = 16'd7;
    @(negedge clk); start = 1'b0;
    chk("busy_ignore_start", busy, 1);
    wait_done(40);

    // start in DONE begins a new run; done drops right away
    start_run(16'd2, 8, 2, 0, 1'b0, 16'h0, 16'h0, 1'b0, 17'h0);
    chk("done_falls", done, 0);
    chk("rerun_busy", busy, 1);
    chk("rerun_pass_clr", pass_count, 0);
    wait_done(30);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hc_adder_tester.md
HC_ADDER_TESTER -- requirements
Module: hc_adder_tester

Purpose: on-board stimulus/check stage placed directly upstream of the 16-bit prefix adder. It drives a, b and cin into the adder, samples s and cout, and checks them against a+b+cin.

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, giving the number of wait cycles after LOAD before the result is sampled; legal range 1..255.
REQ-003 SHALL have parameter SEED, default 16'hACE1, the LFSR seed; it must not be 16'h0000 or 16'hFFFF.
REQ-004 Ports, as name / direction / width / meaning:
- clk / in / 1 / clock
- rst / in / 1 / synchronous active-high reset
- start / in / 1 / begin a run
- num_vectors / in / 16 / vectors per run, sampled with start
- dut_a, dut_b / out / 16 each / adder operands, registered
- dut_cin / out / 1 / adder carry-in, registered
- dut_s / in / 16 / adder sum
- dut_cout / in / 1 / adder carry-out
- busy / out / 1 / run in progress
- done / out / 1 / run complete
- pass_count, fail_count / out / 16 each / check tallies
- fail_seen / out / 1 / at least one mismatch
- ff_a, ff_b / out / 16 each / operands of the first failing vector
- ff_cin / out / 1 / carry-in of the first failing vector
- ff_got / out / 17 / {dut_cout, dut_s} captured for the first failing vector

Function
REQ-005 SHALL implement the FSM states IDLE, LOAD, SETTLE, CHECK and DONE.
REQ-006 IDLE with start=1 and num_vectors!=0: SHALL latch num_vectors, clear counters, fail_seen and the ff_* registers, drive vector 0, and go to LOAD.
REQ-007 IDLE with start=1 and num_vectors==0: SHALL clear counters and go directly to DONE.
REQ-008 LOAD SHALL last one cycle and then go to SETTLE; SETTLE SHALL last exactly SETTLE_CYCLES cycles and then go to CHECK.
REQ-009 CHECK (one cycle) SHALL compare {dut_cout, dut_s} with the 17-bit value {1'b0,dut_a}+{1'b0,dut_b}+dut_cin:
- match: increment pass_count;
- mismatch: increment fail_count.
REQ-010 On the first mismatch of a run, CHECK SHALL capture dut_a, dut_b, dut_cin and {dut_cout, dut_s} into ff_* and set fail_seen; later mismatches SHALL NOT overwrite ff_*.
REQ-011 CHECK SHALL go to DONE after the last vector; otherwise it SHALL drive the next vector and go to LOAD.
REQ-012 Operands SHALL change only on the edge that enters LOAD, and SHALL stay stable through LOAD, SETTLE and CHECK. The adder therefore gets SETTLE_CYCLES+1 full cycles to settle.
REQ-013 Vector sequence, as index: a, b, cin:
- 0: 0000, 0000, 0
- 1: FFFF, 0001, 0
- 2: FFFF, FFFF, 1
- index i>=3: a = LFSR_A, b = LFSR_B, cin = LFSR_A[15]^LFSR_B[15]; both LFSRs then step once.
REQ-014 LFSR step SHALL be next = {q[14:0], q[15]^q[13]^q[12]^q[10]}. On run start LFSR_A SHALL load SEED and LFSR_B SHALL load SEED^16'hFFFF.
REQ-015 busy SHALL be 1 in LOAD, SETTLE and CHECK, and 0 otherwise; done SHALL be 1 only in DONE.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 start=1 in DONE SHALL begin a new run exactly as from IDLE; DONE SHALL otherwise hold all results.
REQ-018 done SHALL first read 1 N*(SETTLE_CYCLES+2) edges after the edge that samples start, for N=num_vectors>0.
REQ-019 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-020 The vector index SHALL be 16 bits, and num_vectors=16'hFFFF SHALL run 65535 vectors.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE and clear to 0: busy, done, dut_a, dut_b, dut_cin, pass_count, fail_count, fail_seen, ff_a, ff_b, ff_cin, ff_got. It SHALL also reload both LFSRs.
REQ-022 rst SHALL take priority over start and over any state, including mid-run; no count update SHALL occur on that edge.

Verification
REQ-023 Reset: hold rst for 3 cycles with start=1 -> all outputs are 0 and the FSM is in IDLE; no run begins until start is seen with rst=0.
REQ-024 Correct adder model, SETTLE_CYCLES=2, start with num_vectors=4:
- done rises 16 edges after start, with pass_count=4, fail_count=0, fail_seen=0;
- vector 3 drives a=ACE1, b=531E, cin=1, and the model returns s=0000, cout=1.
REQ-025 Model with dut_s[0] stuck at 0, num_vectors=3:
- vectors 0 and 1 pass;
- vector 2 fails, giving pass_count=2, fail_count=1, ff_a=FFFF, ff_b=FFFF, ff_cin=1, ff_got=17'h1FFFE.
REQ-026 start with num_vectors=0 -> done=1 on the next cycle, busy never asserts, counts are 0.
REQ-027 Reset mid-run, asserted during SETTLE of vector 1 -> IDLE on the next cycle with all outputs 0; a fresh start then reproduces the REQ-024 results.
REQ-028 start pulsed while busy -> no effect on the run. start pulsed in DONE -> counters clear and a new run starts; done falls on the following cycle.
